// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared width, opcode and state definitions for the ALU driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int W = 4;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_MOD  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_LAND = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

endpackage

`default_nettype wire

// File: rtl/alu_rsp_fifo.sv
// ============================================================================
// Module  : alu_rsp_fifo
// Brief   : Small count-based response FIFO, any depth from 1 to 4.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 5,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] c_last  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_full    = (r_count == c_depth);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_push    = push & ~w_full;
  assign w_pop     = pop & ~empty;
  assign head_data = r_mem[r_rd_ptr];

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_driver.sv
// ============================================================================
// Module  : alu_driver
// Brief   : Accumulator-based command driver for an external combinational ALU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_driver #(
  parameter int RSP_DEPTH = 2,
  parameter int W         = alu_pkg::W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_load,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_b,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  output logic         alu_go,
  input  logic [W-1:0] alu_x,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err
);

  import alu_pkg::*;

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0] c_depth = (CW + 1)'(RSP_DEPTH);

  state_t       r_state;
  logic [W-1:0] r_acc;
  logic [W-1:0] r_alu_b;
  logic [2:0]   r_alu_op;
  logic         r_go;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_used;
  logic          w_empty;
  logic          w_accept;
  logic          w_divz;
  logic          w_push;
  rsp_t          w_push_rsp;
  rsp_t          w_head;

  // An in-flight ISSUE already owns a slot, so it counts as occupied.
  assign w_used    = {1'b0, w_count} + {{CW{1'b0}}, (r_state == ST_ISSUE)};
  assign cmd_ready = (r_state == ST_IDLE) && (w_used < c_depth);
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_divz    = ((cmd_op == OP_DIV) || (cmd_op == OP_MOD)) && (cmd_b == '0);

  always_comb begin
    w_push     = 1'b0;
    w_push_rsp = '0;
    if (r_state == ST_ISSUE) begin
      w_push     = 1'b1;
      w_push_rsp = '{data: alu_x, err: 1'b0};
    end else if (w_accept && cmd_load) begin
      w_push     = 1'b1;
      w_push_rsp = '{data: cmd_b, err: 1'b0};
    end else if (w_accept && w_divz) begin
      w_push     = 1'b1;
      w_push_rsp = '{data: r_acc, err: 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_alu_b  <= '0;
      r_alu_op <= OP_ADD;
      r_go     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (cmd_load) begin
              r_acc <= cmd_b;
            end else if (!w_divz) begin
              r_alu_b  <= cmd_b;
              r_alu_op <= cmd_op;
              r_go     <= 1'b1;
              r_state  <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_acc   <= alu_x;
          r_go    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_go    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  alu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .DW    (RSP_W),
    .CW    (CW)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_rsp),
    .pop       (rsp_valid & rsp_ready),
    .head_data (w_head),
    .count     (w_count),
    .empty     (w_empty)
  );

  assign alu_a     = r_acc;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign alu_go    = r_go;
  assign rsp_valid = ~w_empty;
  assign rsp_data  = w_head.data;
  assign rsp_err   = w_head.err;

endmodule

`default_nettype wire

// File: tb/tb_alu_driver.sv
// ============================================================================
// Module  : tb_alu_driver
// Brief   : Directed and random checks of alu_driver against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_driver;

  localparam int RSP_DEPTH = 2;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [3:0] cmd_b;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic       alu_go;
  logic [3:0] alu_x;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;

  int n_checks;
  int n_errors;

  // Reference state: expected responses in order plus the accumulator.
  logic [4:0] q[$];
  int         m_acc;
  bit         exp_go;
  logic [2:0] m_op;
  logic [3:0] m_b;

  alu_driver #(.RSP_DEPTH(RSP_DEPTH), .W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_op    (cmd_op),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_go    (alu_go),
    .alu_x     (alu_x),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the external combinational ALU.
  always_comb begin
    alu_x = 4'd0;
    case (alu_op)
      3'd0: alu_x = alu_a + alu_b;
      3'd1: alu_x = alu_a - alu_b;
      3'd2: alu_x = alu_a * alu_b;
      3'd3: alu_x = (alu_b == 4'd0) ? 4'd0 : alu_a / alu_b;
      3'd4: alu_x = (alu_b == 4'd0) ? 4'd0 : alu_a % alu_b;
      3'd5: alu_x = alu_a ^ alu_b;
      3'd6: alu_x = ~alu_a;
      3'd7: alu_x = ((alu_a != 4'd0) && (alu_b != 4'd0)) ? 4'd1 : 4'd0;
      default: alu_x = 4'd0;
    endcase
  end

  function automatic int ref_alu(input int a, input int b, input int op);
    case (op)
      0: return (a + b) % 16;
      1: return (a - b + 16) % 16;
      2: return (a * b) % 16;
      3: return a / b;
      4: return a % b;
      5: return a ^ b;
      6: return 15 - a;
      default: return (a != 0 && b != 0) ? 1 : 0;
    endcase
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    assert (act === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock: check at the falling edge, update the model, advance.
  task automatic cycle(output bit accepted);
    int  pend;
    int  r;
    pend = exp_go ? 1 : 0;
    chk("cmd_ready", int'(cmd_ready), int'(!exp_go && q.size() < RSP_DEPTH));
    chk("rsp_valid", int'(rsp_valid), int'((q.size() - pend) > 0));
    chk("alu_go", int'(alu_go), int'(exp_go));
    if (!exp_go) begin
      chk("alu_a", int'(alu_a), m_acc);
    end else begin
      chk("alu_op", int'(alu_op), int'(m_op));
      chk("alu_b", int'(alu_b), int'(m_b));
    end
    if (rsp_valid && rsp_ready && (q.size() - pend) > 0) begin
      chk("rsp_data", int'(rsp_data), int'(q[0][4:1]));
      chk("rsp_err", int'(rsp_err), int'(q[0][0]));
      void'(q.pop_front());
    end
    accepted = cmd_valid && cmd_ready;
    exp_go = 1'b0;
    if (accepted) begin
      if (cmd_load) begin
        m_acc = int'(cmd_b);
        q.push_back({cmd_b, 1'b0});
      end else if ((cmd_op == 3'd3 || cmd_op == 3'd4) && cmd_b == 4'd0) begin
        q.push_back({4'(m_acc), 1'b1});
      end else begin
        r = ref_alu(m_acc, int'(cmd_b), int'(cmd_op));
        m_acc = r;
        m_op = cmd_op;
        m_b = cmd_b;
        q.push_back({4'(r), 1'b0});
        exp_go = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input bit ld, input logic [2:0] op, input logic [3:0] b, input bit rnd_ready);
    bit done;
    done = 1'b0;
    cmd_valid = 1'b1;
    cmd_load = ld;
    cmd_op = op;
    cmd_b = b;
    for (int i = 0; i < 40 && !done; i++) begin
      if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
      cycle(done);
    end
    cmd_valid = 1'b0;
    chk("accept", int'(done), 1);
  endtask

  task automatic idle(input int n);
    bit d;
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(d);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_acc = 0;
    exp_go = 1'b0;
    m_op = 3'd0;
    m_b = 4'd0;
    chk("rst_alu_go", int'(alu_go), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_alu_a", int'(alu_a), 0);
    chk("rst_alu_b", int'(alu_b), 0);
    chk("rst_alu_op", int'(alu_op), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_load = 1'b0;
    cmd_op = 3'd0;
    cmd_b = 4'd0;
    rsp_ready = 1'b0;
    m_acc = 0;
    exp_go = 1'b0;
    m_op = 3'd0;
    m_b = 4'd0;
    @(negedge clk);
    do_reset();

    // load 5, add 3
    rsp_ready = 1'b1;
    send(1'b1, 3'd0, 4'd5, 1'b0);
    send(1'b0, 3'd0, 4'd3, 1'b0);
    idle(3);
    chk("acc_after_add", int'(alu_a), 8);

    // load 9, sub 12; load 6, mul 3
    send(1'b1, 3'd0, 4'd9, 1'b0);
    send(1'b0, 3'd1, 4'd12, 1'b0);
    idle(3);
    chk("acc_after_sub", int'(alu_a), 13);
    send(1'b1, 3'd0, 4'd6, 1'b0);
    send(1'b0, 3'd2, 4'd3, 1'b0);
    idle(3);
    chk("acc_after_mul", int'(alu_a), 2);

    // load 7, div 0 rejected, then mod 3
    send(1'b1, 3'd0, 4'd7, 1'b0);
    send(1'b0, 3'd3, 4'd0, 1'b0);
    idle(2);
    chk("acc_after_divz", int'(alu_a), 7);
    send(1'b0, 3'd4, 4'd3, 1'b0);
    idle(3);
    chk("acc_after_mod", int'(alu_a), 1);

    // Back-pressure with a full FIFO
    rsp_ready = 1'b0;
    send(1'b1, 3'd0, 4'd1, 1'b0);
    send(1'b0, 3'd0, 4'd1, 1'b0);
    idle(2);
    chk("full_blocks", int'(cmd_ready), 0);
    chk("full_head", int'(rsp_data), 1);
    rsp_ready = 1'b1;
    send(1'b0, 3'd0, 4'd1, 1'b0);
    idle(4);
    chk("acc_after_bp", int'(alu_a), 3);
    chk("bp_drained", q.size(), 0);

    // logical-and to 0, then not-a
    send(1'b1, 3'd0, 4'd4, 1'b0);
    send(1'b0, 3'd7, 4'd0, 1'b0);
    idle(3);
    chk("acc_after_land", int'(alu_a), 0);
    send(1'b0, 3'd6, 4'd5, 1'b0);
    idle(3);
    chk("acc_after_nota", int'(alu_a), 15);

    // Reset while an ALU command is in ISSUE
    send(1'b1, 3'd0, 4'd4, 1'b0);
    idle(2);
    send(1'b0, 3'd7, 4'd0, 1'b0);
    chk("in_issue", int'(alu_go), 1);
    do_reset();
    idle(2);

    // Random commands with random consumer stalls
    for (int n = 0; n < 300; n++) begin
      send(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15)), 1'b1);
      if ($urandom_range(0, 5) == 0) idle(1);
    end
    rsp_ready = 1'b1;
    idle(RSP_DEPTH + 4);
    chk("final_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
